// File: rtl/seq_pattern_gen.sv
// Serial pattern burst generator: shifts a captured pattern out MSB first,
// holding each bit BIT_CYCLES clocks, repeating with optional idle gaps.
module seq_pattern_gen #(
   parameter int PAT_W      = 4,
   parameter int BIT_CYCLES = 4,
   parameter int GAP_CYCLES = 4,
   parameter int REP_W      = 4
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [PAT_W-1:0] i_pattern,
   input  logic [REP_W-1:0] i_repeat,
   output logic             o_bit,
   output logic             o_valid,
   output logic             o_busy,
   output logic             o_frame_start,
   output logic             o_done
);

   localparam int CW = $clog2(BIT_CYCLES + 1);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IW-1:0] IDX_MSB  = IW'(PAT_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [IW-1:0]    idx_dec;
   logic             bit_q, bit_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             fs_q, fs_d;
   logic             done_q, done_d;

   assign idx_dec = idx_q - IW'(1);

   // Outputs are computed for the state being entered and registered with it.
   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      rep_d     = rep_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      idx_d     = idx_q;
      bit_d     = 1'b0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      fs_d      = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start && !i_abort) begin
               state_d   = S_SHIFT;
               pat_d     = i_pattern;
               rep_d     = i_repeat;
               bit_cnt_d = '0;
               idx_d     = IDX_MSB;
               bit_d     = i_pattern[PAT_W-1];
               valid_d   = 1'b1;
               busy_d    = 1'b1;
               fs_d      = 1'b1;
            end
         end
         S_SHIFT: begin
            busy_d = 1'b1;
            if (bit_cnt_q != BIT_LAST) begin
               bit_cnt_d = bit_cnt_q + CW'(1);
               bit_d     = pat_q[idx_q];
               valid_d   = 1'b1;
            end else if (idx_q != '0) begin
               bit_cnt_d = '0;
               idx_d     = idx_dec;
               bit_d     = pat_q[idx_dec];
               valid_d   = 1'b1;
            end else if (rep_q == '0) begin
               state_d   = S_DONE;
               bit_cnt_d = '0;
               done_d    = 1'b1;
            end else begin
               // rep_q counts repetitions still owed, so it never wraps.
               rep_d     = rep_q - REP_W'(1);
               bit_cnt_d = '0;
               idx_d     = IDX_MSB;
               if (GAP_CYCLES > 0) begin
                  state_d   = S_GAP;
                  gap_cnt_d = '0;
               end else begin
                  bit_d   = pat_q[PAT_W-1];
                  valid_d = 1'b1;
                  fs_d    = 1'b1;
               end
            end
         end
         S_GAP: begin
            busy_d = 1'b1;
            if (gap_cnt_q == GAP_LAST) begin
               state_d   = S_SHIFT;
               gap_cnt_d = '0;
               bit_d     = pat_q[PAT_W-1];
               valid_d   = 1'b1;
               fs_d      = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (i_abort && state_q != S_IDLE) begin
         state_d   = S_IDLE;
         rep_d     = '0;
         bit_cnt_d = '0;
         gap_cnt_d = '0;
         idx_d     = '0;
         bit_d     = 1'b0;
         valid_d   = 1'b0;
         busy_d    = 1'b0;
         fs_d      = 1'b0;
         done_d    = 1'b0;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= S_IDLE;
         pat_q     <= '0;
         rep_q     <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         idx_q     <= '0;
         bit_q     <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         fs_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         rep_q     <= rep_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         idx_q     <= idx_d;
         bit_q     <= bit_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         fs_q      <= fs_d;
         done_q    <= done_d;
      end
   end

   assign o_bit         = bit_q;
   assign o_valid       = valid_q;
   assign o_busy        = busy_q;
   assign o_frame_start = fs_q;
   assign o_done        = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: default instance plus a no-gap, one-cycle-per-bit
// instance; a cycle model fills the expected queue for every burst.
module tb_seq_pattern_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start0, start1, abort0, abort1;
   logic [3:0] pattern, repeat_n;
   logic       bit0, valid0, busy0, fs0, done0;
   logic       bit1, valid1, busy1, fs1, done1;

   always #5 clk = ~clk;

   seq_pattern_gen dut0 (
      .i_clock(clk), .i_reset(rst), .i_start(start0), .i_abort(abort0),
      .i_pattern(pattern), .i_repeat(repeat_n),
      .o_bit(bit0), .o_valid(valid0), .o_busy(busy0),
      .o_frame_start(fs0), .o_done(done0)
   );

   seq_pattern_gen #(.BIT_CYCLES(1), .GAP_CYCLES(0)) dut1 (
      .i_clock(clk), .i_reset(rst), .i_start(start1), .i_abort(abort1),
      .i_pattern(pattern), .i_repeat(repeat_n),
      .o_bit(bit1), .o_valid(valid1), .o_busy(busy1),
      .o_frame_start(fs1), .o_done(done1)
   );

   // Output vector layout: {busy, valid, bit, frame_start, done}
   logic [4:0] exp_q[$];
   int tests = 0;
   int fails = 0;

   typedef struct {
      int         sel;
      logic [3:0] pat;
      logic [3:0] rep;
      bit         noisy;
      int         exp_frames;
      int         exp_busy;
   } vec_t;

   vec_t vecs[7];

   function automatic logic [4:0] outs(input int sel);
      if (sel == 1) return {busy1, valid1, bit1, fs1, done1};
      return {busy0, valid0, bit0, fs0, done0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_model(input int bc, input int gc, input logic [3:0] pat, input logic [3:0] rep);
      for (int f = 0; f <= int'(rep); f++) begin
         for (int b = 3; b >= 0; b--)
            for (int c = 0; c < bc; c++)
               exp_q.push_back({1'b1, 1'b1, pat[b], (b == 3 && c == 0), 1'b0});
         if (f < int'(rep))
            for (int g = 0; g < gc; g++) exp_q.push_back(5'b10000);
      end
      exp_q.push_back(5'b10001);
      exp_q.push_back(5'b00000);
   endtask

   task automatic run_burst(input int sel, input logic [3:0] pat, input logic [3:0] rep,
                            input bit noisy, output int frames, output int busy_cyc,
                            output int dones);
      logic [4:0] o, e;
      int cyc;
      frames = 0; busy_cyc = 0; dones = 0; cyc = 0;
      exp_q.delete();
      @(negedge clk);
      pattern  = pat;
      repeat_n = rep;
      if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
      if (sel == 1) push_model(1, 0, pat, rep); else push_model(4, 4, pat, rep);
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      while (exp_q.size() > 0) begin
         cyc++;
         o = outs(sel);
         e = exp_q.pop_front();
         check($sformatf("burst_out sel%0d cyc%0d", sel, cyc), 32'(o), 32'(e));
         frames   += int'(o[1]);
         busy_cyc += int'(o[4]);
         dones    += int'(o[0]);
         if (noisy && exp_q.size() > 0) begin
            if (sel == 1) start1 = 1'($urandom_range(0, 1));
            else start0 = 1'($urandom_range(0, 1));
            pattern  = 4'($urandom_range(0, 15));
            repeat_n = 4'($urandom_range(0, 15));
         end else begin
            start0 = 1'b0; start1 = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int fr, bc, dn;
      rst = 1'b1; start0 = 0; start1 = 0; abort0 = 0; abort1 = 0;
      pattern = '0; repeat_n = '0;

      vecs[0] = '{0, 4'b1010, 4'd0,  1'b0, 1,  17};
      vecs[1] = '{0, 4'b1010, 4'd2,  1'b0, 3,  57};
      vecs[2] = '{1, 4'b1101, 4'd1,  1'b0, 2,  9};
      vecs[3] = '{0, 4'b0110, 4'd1,  1'b0, 2,  37};
      vecs[4] = '{1, 4'b1001, 4'd15, 1'b0, 16, 65};
      vecs[5] = '{0, 4'b1100, 4'd1,  1'b1, 2,  37};
      vecs[6] = '{0, 4'b0001, 4'd0,  1'b0, 1,  17};

      repeat (2) @(negedge clk);
      check("reset_outs0", 32'(outs(0)), 32'h0);
      check("reset_outs1", 32'(outs(1)), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_outs0", 32'(outs(0)), 32'h0);

      for (int i = 0; i < 7; i++) begin
         run_burst(vecs[i].sel, vecs[i].pat, vecs[i].rep, vecs[i].noisy, fr, bc, dn);
         check($sformatf("vec%0d frames", i), 32'(fr), 32'(vecs[i].exp_frames));
         check($sformatf("vec%0d busy_cycles", i), 32'(bc), 32'(vecs[i].exp_busy));
         check($sformatf("vec%0d dones", i), 32'(dn), 32'd1);
      end

      for (int i = 0; i < 3; i++) begin
         run_burst(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 1'b0, fr, bc, dn);
         check("rand dones", 32'(dn), 32'd1);
      end

      // Abort during cycle 6 of a burst
      @(negedge clk);
      pattern = 4'b1010; repeat_n = 4'd2; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         check($sformatf("abort_pre_valid cyc%0d", c), 32'(valid0), 32'd1);
         @(negedge clk);
      end
      abort0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0;
      check("abort_outs", 32'(outs(0)), 32'h0);
      dn = 0;
      for (int c = 0; c < 30; c++) begin
         dn += int'(done0) + int'(busy0);
         @(negedge clk);
      end
      check("abort_no_done_no_busy", 32'(dn), 32'd0);

      // Start and abort together in IDLE
      start0 = 1'b1; abort0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; abort0 = 1'b0;
      check("start_abort_busy", 32'(busy0), 32'd0);
      @(negedge clk);
      check("start_abort_busy_later", 32'(outs(0)), 32'h0);

      // Asynchronous reset in the middle of the first gap
      pattern = 4'b1010; repeat_n = 4'd2; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (17) @(negedge clk);
      check("pre_reset_in_gap", 32'(outs(0)), 32'h10);
      #2 rst = 1'b1;
      #1 check("async_reset_outs0", 32'(outs(0)), 32'h0);
      check("async_reset_outs1", 32'(outs(1)), 32'h0);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_reset_idle", 32'(outs(0)), 32'h0);
      run_burst(0, 4'b1010, 4'd0, 1'b0, fr, bc, dn);
      check("post_reset frames", 32'(fr), 32'd1);
      check("post_reset dones", 32'(dn), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- PAT_W, 4, pattern length in bits.
- BIT_CYCLES, 4, clocks each bit is held (>=1).
- GAP_CYCLES, 4, idle clocks between repetitions (0 = no gap).
- REP_W, 4, width of the repeat-count input.
REQ-002 Ports SHALL be (name direction width meaning):
- i_clock input 1: single clock; all logic on rising edge.
- i_reset input 1: asynchronous, active-high reset.
- i_start input 1: request to begin a burst; sampled only in IDLE.
- i_abort input 1: terminate the burst immediately.
- i_pattern input PAT_W: pattern to send, MSB first; captured at start.
- i_repeat input REP_W: burst sends i_repeat+1 repetitions; captured at start.
- o_bit output 1: serial pattern bit.
- o_valid output 1: high while o_bit carries a pattern bit.
- o_busy output 1: high in any state other than IDLE.
- o_frame_start output 1: one-cycle pulse on the first cycle of each repetition.
- o_done output 1: one-cycle pulse on normal burst completion.

Function
REQ-003 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-004 The FSM SHALL have states IDLE, SHIFT, GAP, DONE.
REQ-005 IDLE -> SHIFT on a clock edge with i_start=1 and i_abort=0; i_pattern and i_repeat are loaded into internal registers on that edge.
REQ-006 In the first SHIFT cycle (the cycle after acceptance):
- o_bit = pattern[PAT_W-1]; o_valid=1; o_frame_start=1.
REQ-007 Each bit SHALL be held exactly BIT_CYCLES clocks, then the next lower bit is driven; one repetition lasts PAT_W*BIT_CYCLES clocks.
REQ-008 Transitions after the last bit's final cycle:
- Repetitions remain and GAP_CYCLES>0 -> GAP.
- Repetitions remain and GAP_CYCLES=0 -> SHIFT directly, restarting at the MSB with o_frame_start=1.
- No repetitions remain -> DONE.
REQ-009 GAP SHALL last exactly GAP_CYCLES clocks with o_valid=0 and o_bit=0, then enter SHIFT at the MSB with o_frame_start=1.
REQ-010 DONE SHALL last one clock with o_done=1, o_valid=0, o_bit=0, then return to IDLE.
REQ-011 o_busy SHALL be 1 in SHIFT, GAP and DONE, and 0 in IDLE.
REQ-012 i_start outside IDLE SHALL be ignored; captured pattern and repeat registers SHALL NOT change mid-burst.
REQ-013 i_abort=1 in SHIFT, GAP or DONE SHALL force IDLE on the next edge:
- o_valid=0, o_bit=0, o_busy=0.
- No o_done pulse; counters cleared.
REQ-014 If i_start and i_abort are both high in IDLE, abort SHALL win and no burst starts.
REQ-015 The repeat counter SHALL decrement once per completed repetition and SHALL NOT wrap; i_repeat = all-ones gives 2^REP_W repetitions.
REQ-016 The bit-cycle counter SHALL be $clog2(BIT_CYCLES+1) bits wide, the gap counter $clog2(GAP_CYCLES+1) bits wide, and the bit index $clog2(PAT_W) bits wide.
REQ-017 If i_start is high on the DONE cycle, it SHALL be ignored; a new burst needs i_start high while in IDLE.

Reset
REQ-018 Asserting i_reset SHALL immediately, without waiting for a clock edge:
- Force IDLE.
- Clear all counters and capture registers.
- Drive o_bit, o_valid, o_busy, o_frame_start and o_done to 0.
REQ-019 Reset asserted mid-burst SHALL discard the burst; after deassertion the block waits in IDLE for a new i_start.

Verification
REQ-020 Benches SHALL cover, with default parameters unless stated:
- Basic: pattern=4'b1010, repeat=0, one-cycle start -> o_bit 1111 0000 1111 0000 over 16 cycles with o_valid=1; o_frame_start on cycle 1; o_done on cycle 17; o_busy low on cycle 18.
- Repeat with gap: pattern=4'b1010, repeat=2 -> 3 frames of 16 valid cycles, each separated by 4 cycles of o_valid=0; 3 o_frame_start pulses; one o_done.
- No gap: GAP_CYCLES=0, BIT_CYCLES=1, pattern=4'b1101, repeat=1 -> o_bit 11011101 on 8 consecutive valid cycles; o_frame_start on cycles 1 and 5.
- Abort: abort on cycle 6 of a burst -> next cycle o_busy=0, o_valid=0, no o_done. Simultaneous start+abort in IDLE -> o_busy stays 0.
- Reset: i_reset pulsed mid-GAP without a clock edge -> all outputs 0 immediately; a later start runs a full correct burst.
- Ignored inputs: start and pattern changes while busy -> output sequence unchanged, exactly one o_done.
